// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random-number scheduler.
//   state_e       scheduler sequence: seed load, warm-up, serve
//   LFSR_W        LFSR / data width
//   DEFAULT_SEED  seed in effect after reset until the host loads one
//   TAP_MASK      feedback taps (bits 7,5,4,3), shared with the LFSR itself
//   lfsr_step     one Fibonacci step: shift left, feedback = parity(state & taps)
package lfsr_pkg;
  typedef enum logic [1:0] {ST_SEED, ST_WARMUP, ST_SERVE} state_e;

  localparam int              LFSR_W       = 8;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'hD3;
  localparam logic [LFSR_W-1:0] TAP_MASK     = 8'b1011_1000;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & TAP_MASK)};
  endfunction
endpackage

// File: rtl/lfsr_rng_sched_if.sv
// Host-side bus of the scheduler.
//   seed_in/seed_load  host seed request (master -> scheduler)
//   req                per-requester request, held until gnt
//   gnt/rnd_data/rnd_valid  one-cycle grant with its random value
//   busy               scheduler not yet serving
interface lfsr_rng_sched_if
  import lfsr_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = LFSR_W
);
  logic [WIDTH-1:0]   seed_in;
  logic               seed_load;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [WIDTH-1:0]   rnd_data;
  logic               rnd_valid;
  logic               busy;

  modport master (output seed_in, seed_load, req,
                  input  gnt, rnd_data, rnd_valid, busy);
  modport slave  (input  seed_in, seed_load, req,
                  output gnt, rnd_data, rnd_valid, busy);
endinterface

// File: rtl/lfsr_rng_sched_rr_arbiter.sv
// Combinational round-robin pick.
//   req_i     request vector
//   ptr_i     highest-priority index this cycle
//   winner_o  first set bit at or above ptr_i, wrapping modulo NUM_REQ
//   any_o     at least one request present
module rr_arbiter
  import lfsr_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [PW-1:0]      winner_o,
  output logic               any_o
);
  int idx;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    winner_o = '0;
    idx      = 0;
    any_o    = |req_i;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr_i) + i) % NUM_REQ;
      if (req_i[idx]) winner_o = PW'(idx);
    end
  end
endmodule

// File: rtl/lfsr_rng_sched.sv
// Scheduler sharing one LFSR among NUM_REQ requesters.
//   clk, rst         clock, asynchronous active-high reset
//   bus (slave)      host seed request, req/gnt handshake, rnd_data/rnd_valid, busy
//   lfsr_seed_o      seed presented to the LFSR (never all-zero)
//   lfsr_rst_o       LFSR loads lfsr_seed_o on an edge where this is high
//   lfsr_enable_o    LFSR steps on an edge where this is high
//   lfsr_out_i       current LFSR state
//   lfsr_complete_i  LFSR period-complete flag
// Optional feature macro LFSR_EPOCH_MIX_EN: XOR an epoch counter (bumped on every
// period-complete reseed, cleared by seed_load) into the seed so periods differ.
module lfsr_rng_sched
  import lfsr_pkg::*;
#(
  parameter int               NUM_REQ      = 4,
  parameter int               WIDTH        = LFSR_W,
  parameter int               WARMUP       = 8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = lfsr_pkg::DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst,
  lfsr_rng_sched_if.slave  bus,
  output logic [WIDTH-1:0] lfsr_seed_o,
  output logic             lfsr_rst_o,
  output logic             lfsr_enable_o,
  input  logic [WIDTH-1:0] lfsr_out_i,
  input  logic             lfsr_complete_i
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      warm_cnt_q, warm_cnt_d;
  logic [WIDTH-1:0]   seed_q;
  logic [PW-1:0]      rr_ptr_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [WIDTH-1:0]   rnd_q;
  logic               vld_q;
  logic [PW-1:0]      winner;
  logic               any;
  logic               grant_fire;
  logic [WIDTH-1:0]   seed_raw;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .req_i    (bus.req),
    .ptr_i    (rr_ptr_q),
    .winner_o (winner),
    .any_o    (any)
  );

  // seed_load suppresses the grant so the in-flight LFSR value is not consumed.
  assign grant_fire    = (state_q == ST_SERVE) & any & ~bus.seed_load;
  assign lfsr_rst_o    = (state_q == ST_SEED);
  assign lfsr_enable_o = (state_q == ST_WARMUP) | grant_fire;

  assign bus.gnt       = gnt_q;
  assign bus.rnd_data  = rnd_q;
  assign bus.rnd_valid = vld_q;
  assign bus.busy      = (state_q != ST_SERVE);

`ifdef LFSR_EPOCH_MIX_EN
  logic [WIDTH-1:0] epoch_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                             epoch_q <= '0;
    else if (bus.seed_load)                              epoch_q <= '0;
    else if ((state_q == ST_SERVE) && lfsr_complete_i)   epoch_q <= epoch_q + 1'b1;
  end

  assign seed_raw = seed_q ^ epoch_q;
`else
  assign seed_raw = seed_q;
`endif

  // An all-zero seed would lock the LFSR; substitute 1.
  assign lfsr_seed_o = (seed_raw == '0) ? WIDTH'(1) : seed_raw;

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    case (state_q)
      ST_SEED: begin
        warm_cnt_d = '0;
        state_d    = (WARMUP > 0) ? ST_WARMUP : ST_SERVE;
      end
      ST_WARMUP: begin
        warm_cnt_d = warm_cnt_q + 1'b1;
        if (warm_cnt_q == CW'(WARMUP - 1)) state_d = ST_SERVE;
      end
      ST_SERVE: begin
        if (lfsr_complete_i) state_d = ST_SEED;
      end
      default: state_d = ST_SEED;
    endcase
    if (bus.seed_load) state_d = ST_SEED;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_SEED;
      warm_cnt_q <= '0;
      seed_q     <= DEFAULT_SEED;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      rnd_q      <= '0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      if (bus.seed_load) seed_q <= bus.seed_in;
      gnt_q <= grant_fire ? (NUM_REQ'(1) << winner) : '0;
      vld_q <= grant_fire;
      if (grant_fire) begin
        rnd_q    <= lfsr_out_i;
        rr_ptr_q <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_lfsr_rng_sched.sv
module tb_lfsr_rng_sched;
  import lfsr_pkg::*;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int WU = 8;
`ifdef LFSR_EPOCH_MIX_EN
  localparam logic [W-1:0] EXP_RESEED = 8'hD2;
`else
  localparam logic [W-1:0] EXP_RESEED = 8'hD3;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lfsr_rng_sched_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();
  logic [W-1:0] lfsr_seed, lfsr_out, lfsr_q;
  logic         lfsr_rst, lfsr_enable, lfsr_complete;

  lfsr_rng_sched #(.NUM_REQ(NR), .WIDTH(W), .WARMUP(WU), .DEFAULT_SEED(8'hD3)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus.slave),
    .lfsr_seed_o     (lfsr_seed),
    .lfsr_rst_o      (lfsr_rst),
    .lfsr_enable_o   (lfsr_enable),
    .lfsr_out_i      (lfsr_out),
    .lfsr_complete_i (lfsr_complete)
  );

  // Stand-in for the external LFSR instance.
  initial lfsr_q = '0;
  always @(posedge clk) begin
    if (lfsr_rst)         lfsr_q <= lfsr_seed;
    else if (lfsr_enable) lfsr_q <= lfsr_step(lfsr_q);
  end
  assign lfsr_out = lfsr_q;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: round-robin pointer, active seed, values consumed since seed.
  int           m_ptr;
  logic [W-1:0] m_seed;
  int           m_pos;
  logic [W-1:0] m_last;
  logic [W-1:0] seen[$];

  // n steps of the tap-mask recurrence, computed by counting tap bits.
  function automatic logic [W-1:0] ref_state(input logic [W-1:0] s, input int n);
    logic [W-1:0] x;
    int ones;
    x = s;
    for (int k = 0; k < n; k++) begin
      ones = 0;
      for (int b = 0; b < W; b++) if (TAP_MASK[b] && x[b]) ones++;
      x = {x[W-2:0], 1'b0} | W'(ones % 2);
    end
    return x;
  endfunction

  function automatic int ref_pick(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < NR; k++) if (r[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  function automatic logic [W-1:0] guard(input logic [W-1:0] s);
    return (s == '0) ? W'(1) : s;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_seed = 8'hD3; m_pos = 0; m_last = '0; seen.delete();
  endtask

  task automatic model_reseed(input logic [W-1:0] s);
    m_seed = s; m_pos = 0; seen.delete();
  endtask

  // Assert reset, release at a negedge; returns at a negedge in SEED.
  task automatic apply_reset();
    rst = 1'b1;
    bus.req = '0; bus.seed_load = 1'b0; bus.seed_in = '0; lfsr_complete = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // From a negedge in SEED, advance to the first negedge in SERVE.
  task automatic skip_to_serve();
    repeat (WU + 1) @(negedge clk);
  endtask

  task automatic test_reset();
    int en_cnt;
    bit done;
    rst = 1'b1;
    bus.req = '0; bus.seed_load = 1'b0; bus.seed_in = '0; lfsr_complete = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.gnt, bus.rnd_data, bus.rnd_valid, bus.busy, lfsr_rst} !== {4'b0, 8'h00, 1'b0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_state: gnt=%b rnd=%h vld=%b busy=%b lrst=%b, want 0000 00 0 1 1",
               bus.gnt, bus.rnd_data, bus.rnd_valid, bus.busy, lfsr_rst);
    end
    rst = 1'b0;
    model_reset();
    vectors++;
    if (lfsr_rst !== 1'b1 || lfsr_seed !== 8'hD3) begin
      miscompares++;
      $display("FAIL reset_seed: lrst=%b seed=%h, want 1 d3", lfsr_rst, lfsr_seed);
    end
    en_cnt = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) done = 1;
      else if (lfsr_enable === 1'b1) en_cnt++;
    end
    vectors++;
    if (!done || en_cnt != WU) begin
      miscompares++;
      $display("FAIL warmup_len: enables=%0d reached_serve=%0d, want %0d 1", en_cnt, done, WU);
    end
  endtask

  task automatic test_rr_all();
    int w;
    logic [W-1:0] e;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      w = ref_pick(4'b1111, m_ptr);
      e = ref_state(m_seed, WU + m_pos);
      vectors++;
      if (bus.gnt !== NR'(1 << w) || bus.rnd_valid !== 1'b1 || bus.rnd_data !== e) begin
        miscompares++;
        $display("FAIL rr_all[%0d]: gnt=%b vld=%b rnd=%h, want %b 1 %h",
                 k, bus.gnt, bus.rnd_valid, bus.rnd_data, NR'(1 << w), e);
      end
      vectors++;
      foreach (seen[j]) if (seen[j] == bus.rnd_data) begin
        miscompares++;
        $display("FAIL rr_repeat[%0d]: rnd=%h seen before, want fresh value", k, bus.rnd_data);
      end
      seen.push_back(bus.rnd_data);
      m_ptr = (w + 1) % NR; m_pos++; m_last = e;
    end
    bus.req = '0;
    @(negedge clk);
    vectors++;
    if (bus.gnt !== '0 || bus.rnd_valid !== 1'b0 || bus.rnd_data !== m_last) begin
      miscompares++;
      $display("FAIL idle_hold: gnt=%b vld=%b rnd=%h, want 0000 0 %h",
               bus.gnt, bus.rnd_valid, bus.rnd_data, m_last);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    skip_to_serve();
    bus.req = 4'b0100;
    @(negedge clk);
    vectors++;
    if (bus.gnt !== 4'b0100) begin
      miscompares++;
      $display("FAIL wrap_first: gnt=%b, want 0100", bus.gnt);
    end
    m_ptr = 3; m_pos++;
    bus.req = 4'b0101;
    @(negedge clk);
    vectors++;
    if (bus.gnt !== 4'b0001 || bus.rnd_data !== ref_state(m_seed, WU + m_pos)) begin
      miscompares++;
      $display("FAIL wrap_second: gnt=%b rnd=%h, want 0001 %h",
               bus.gnt, bus.rnd_data, ref_state(m_seed, WU + m_pos));
    end
    m_last = ref_state(m_seed, WU + m_pos);
    m_ptr = 1; m_pos++;
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_seed_load_zero();
    int en_cnt;
    bit done;
    bus.seed_in = 8'h00; bus.seed_load = 1'b1; bus.req = 4'b0001;
    @(negedge clk);
    vectors++;
    if (bus.gnt !== '0 || bus.rnd_valid !== 1'b0 || lfsr_rst !== 1'b1 || lfsr_seed !== 8'h01
        || bus.rnd_data !== m_last) begin
      miscompares++;
      $display("FAIL seed_zero: gnt=%b vld=%b lrst=%b seed=%h rnd=%h, want 0000 0 1 01 %h",
               bus.gnt, bus.rnd_valid, lfsr_rst, lfsr_seed, bus.rnd_data, m_last);
    end
    bus.seed_load = 1'b0; bus.req = '0;
    model_reseed(8'h01);
    en_cnt = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) done = 1;
      else if (lfsr_enable === 1'b1) en_cnt++;
    end
    vectors++;
    if (!done || en_cnt != WU) begin
      miscompares++;
      $display("FAIL seed_zero_warmup: enables=%0d reached_serve=%0d, want %0d 1", en_cnt, done, WU);
    end
    bus.req = 4'b1000;
    @(negedge clk);
    bus.req = '0;
    vectors++;
    if (bus.gnt !== 4'b1000 || bus.rnd_data !== ref_state(8'h01, WU)) begin
      miscompares++;
      $display("FAIL seed_zero_data: gnt=%b rnd=%h, want 1000 %h",
               bus.gnt, bus.rnd_data, ref_state(8'h01, WU));
    end
    m_last = ref_state(8'h01, WU); m_ptr = 0; m_pos = 1;
  endtask

  task automatic test_complete();
    logic [W-1:0] e;
    apply_reset();
    skip_to_serve();
    e = ref_state(8'hD3, WU);
    bus.req = 4'b0010; lfsr_complete = 1'b1;
    @(negedge clk);
    bus.req = '0; lfsr_complete = 1'b0;
    vectors++;
    if (bus.gnt !== 4'b0010 || bus.rnd_data !== e || lfsr_rst !== 1'b1 || lfsr_seed !== EXP_RESEED) begin
      miscompares++;
      $display("FAIL complete: gnt=%b rnd=%h lrst=%b seed=%h, want 0010 %h 1 %h",
               bus.gnt, bus.rnd_data, lfsr_rst, lfsr_seed, e, EXP_RESEED);
    end
    m_ptr = 2;
    model_reseed(EXP_RESEED);
    skip_to_serve();
    bus.req = 4'b0001;
    @(negedge clk);
    bus.req = '0;
    e = ref_state(EXP_RESEED, WU);
    vectors++;
    if (bus.gnt !== 4'b0001 || bus.rnd_data !== e) begin
      miscompares++;
      $display("FAIL complete_next: gnt=%b rnd=%h, want 0001 %h", bus.gnt, bus.rnd_data, e);
    end
    m_last = e; m_ptr = 1; m_pos = 1;
  endtask

  task automatic test_async_rst();
    bus.seed_in = W'($urandom_range(1, 255)); bus.seed_load = 1'b1;
    @(negedge clk);
    bus.seed_load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.gnt !== '0 || bus.rnd_valid !== 1'b0 || bus.rnd_data !== '0 || lfsr_rst !== 1'b1
        || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL async_rst: gnt=%b vld=%b rnd=%h lrst=%b busy=%b, want 0000 0 00 1 1",
               bus.gnt, bus.rnd_valid, bus.rnd_data, lfsr_rst, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    skip_to_serve();
  endtask

  task automatic test_random();
    logic [W-1:0] s, e;
    logic [NR-1:0] r;
    int w;
    for (int it = 0; it < 6; it++) begin
      s = (it == 2) ? 8'h00 : W'($urandom_range(0, 255));
      bus.seed_in = s; bus.seed_load = 1'b1; bus.req = NR'($urandom_range(0, 15));
      @(negedge clk);
      bus.seed_load = 1'b0; bus.req = '0;
      vectors++;
      if (lfsr_rst !== 1'b1 || lfsr_seed !== guard(s) || bus.gnt !== '0) begin
        miscompares++;
        $display("FAIL rand_seed[%0d]: lrst=%b seed=%h gnt=%b, want 1 %h 0000",
                 it, lfsr_rst, lfsr_seed, bus.gnt, guard(s));
      end
      model_reseed(guard(s));
      skip_to_serve();
      for (int c = 0; c < 24; c++) begin
        r = NR'($urandom_range(0, 15));
        bus.req = r;
        @(negedge clk);
        if (r != '0) begin
          w = ref_pick(r, m_ptr);
          e = ref_state(m_seed, WU + m_pos);
          m_ptr = (w + 1) % NR; m_pos++; m_last = e;
          vectors++;
          if (bus.gnt !== NR'(1 << w) || bus.rnd_valid !== 1'b1 || bus.rnd_data !== e) begin
            miscompares++;
            $display("FAIL rand_grant[%0d.%0d]: req=%b gnt=%b vld=%b rnd=%h, want %b 1 %h",
                     it, c, r, bus.gnt, bus.rnd_valid, bus.rnd_data, NR'(1 << w), e);
          end
        end else begin
          vectors++;
          if (bus.gnt !== '0 || bus.rnd_valid !== 1'b0 || bus.rnd_data !== m_last) begin
            miscompares++;
            $display("FAIL rand_idle[%0d.%0d]: gnt=%b vld=%b rnd=%h, want 0000 0 %h",
                     it, c, bus.gnt, bus.rnd_valid, bus.rnd_data, m_last);
          end
        end
      end
      bus.req = '0;
    end
  endtask

  initial begin
    test_reset();
    test_rr_all();
    test_wrap();
    test_seed_load_zero();
    test_complete();
    test_async_rst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
